// File: rtl/xif_scb_pkg.sv
// Shared types and helpers for the XIF instruction-ID scoreboard.
package xif_scb_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } xif_scb_state_e;

  // Width of a counter that must hold the values 0..max_outstanding inclusive.
  function automatic int cnt_width(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/xif_scb_watchdog.sv
// Outstanding-instruction watchdog: counts cycles without forward progress and
// raises a sticky timeout. Only built when XIF_SCB_WATCHDOG_EN is defined.
`ifdef XIF_SCB_WATCHDOG_EN
module xif_scb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic free_i,
  input  logic clr_i,
  output logic err_o,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          hit;

  // Counter holds once expired so the error pulse fires only once per timeout.
  always_comb begin
    cnt_d = cnt_q;
    hit   = 1'b0;
    if (clr_i || free_i || !active_i) begin
      cnt_d = '0;
    end else if (!timeout_q) begin
      cnt_d = cnt_q + CW'(1);
      hit   = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end
    timeout_d = hit | (timeout_q & ~clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign err_o     = hit;
  assign timeout_o = timeout_q;

endmodule
`endif

// File: rtl/xif_scoreboard.sv
// CORE-V-XIF offload scoreboard: ID allocation, outstanding bitmap, drain FSM and
// protocol-error flags. Optional watchdog enabled by defining XIF_SCB_WATCHDOG_EN.
module xif_scoreboard
  import xif_scb_pkg::*;
#(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  issue_valid_i,
  input  logic                                  issue_ready_i,
  input  logic                                  issue_accept_i,
  output logic [ID_WIDTH-1:0]                   next_id_o,
  output logic                                  issue_stall_o,
  input  logic                                  commit_valid_i,
  input  logic [ID_WIDTH-1:0]                   commit_id_i,
  input  logic                                  commit_kill_i,
  input  logic                                  result_valid_i,
  input  logic                                  result_ready_i,
  input  logic [ID_WIDTH-1:0]                   result_id_i,
  input  logic                                  drain_req_i,
  output logic                                  drained_o,
  output logic [(1<<ID_WIDTH)-1:0]              busy_vec_o,
  output logic [cnt_width(MAX_OUTSTANDING)-1:0] outstanding_cnt_o,
  output logic                                  err_o,
  output logic                                  err_sticky_o,
  input  logic                                  err_clr_i,
  output logic                                  timeout_o
);

  localparam int NUM_IDS = 1 << ID_WIDTH;
  localparam int CNT_W   = cnt_width(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > NUM_IDS || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("xif_scoreboard: MAX_OUTSTANDING must be 1..2**ID_WIDTH and TIMEOUT_CYCLES >= 1");
  end

  logic [NUM_IDS-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_WIDTH-1:0] next_id_q, next_id_d;
  xif_scb_state_e      state_q, state_d;
  logic                err_q, err_d, err_sticky_q;
  logic                stall, alloc, alloc_ok, alloc_err;
  logic                free_r, free_k, kill_dup, ok_r, ok_k, bad_r, bad_k;
  logic                wd_err, timeout;

  assign stall = busy_q[next_id_q] | (cnt_q == CNT_W'(MAX_OUTSTANDING)) | (state_q != ST_RUN);

  assign alloc     = issue_valid_i & issue_ready_i & issue_accept_i;
  assign alloc_ok  = alloc & ~stall;
  assign alloc_err = alloc & stall;

  // A result and a kill naming the same ID collapse into one free.
  assign free_r   = result_valid_i & result_ready_i;
  assign free_k   = commit_valid_i & commit_kill_i;
  assign kill_dup = free_r & free_k & (commit_id_i == result_id_i);
  assign ok_r     = free_r & busy_q[result_id_i];
  assign bad_r    = free_r & ~busy_q[result_id_i];
  assign ok_k     = free_k & ~kill_dup & busy_q[commit_id_i];
  assign bad_k    = free_k & ~kill_dup & ~busy_q[commit_id_i];

  always_comb begin
    busy_d = busy_q;
    if (ok_r) busy_d[result_id_i] = 1'b0;
    if (ok_k) busy_d[commit_id_i] = 1'b0;
    if (alloc_ok) busy_d[next_id_q] = 1'b1;
    cnt_d     = cnt_q + CNT_W'(alloc_ok) - CNT_W'(ok_r) - CNT_W'(ok_k);
    next_id_d = alloc_ok ? next_id_q + ID_WIDTH'(1) : next_id_q;
    err_d     = alloc_err | bad_r | bad_k | wd_err;
  end

  // Draining completes on the registered count, so the last free lands first.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:     if (drain_req_i) state_d = (cnt_q != '0) ? ST_DRAIN : ST_DRAINED;
      ST_DRAIN: begin
        if (cnt_q == '0)       state_d = ST_DRAINED;
        else if (!drain_req_i) state_d = ST_RUN;
      end
      ST_DRAINED: if (!drain_req_i) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q       <= '0;
      cnt_q        <= '0;
      next_id_q    <= '0;
      state_q      <= ST_RUN;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      next_id_q    <= next_id_d;
      state_q      <= state_d;
      err_q        <= err_d;
      err_sticky_q <= err_d | (err_sticky_q & ~err_clr_i);
    end
  end

`ifdef XIF_SCB_WATCHDOG_EN
  xif_scb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .active_i  (cnt_q != '0),
    .free_i    (ok_r | ok_k),
    .clr_i     (err_clr_i),
    .err_o     (wd_err),
    .timeout_o (timeout)
  );
`else
  assign wd_err  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign next_id_o         = next_id_q;
  assign issue_stall_o     = stall;
  assign drained_o         = (state_q == ST_DRAINED);
  assign busy_vec_o        = busy_q;
  assign outstanding_cnt_o = cnt_q;
  assign err_o             = err_q;
  assign err_sticky_o      = err_sticky_q;
  assign timeout_o         = timeout;

endmodule
